sequenciador_medicao: RTL and testbench

- Controller that sequences one level-measurement cycle for the water-level sensing path.
- Requests three consecutive samples from the distance sensor interface and presents them to the measurement classifier.
- Clears and starts the classifier, then publishes its average and class.
- Retries when the classifier flags a sample set for discard, and repeats the whole cycle at a fixed interval while enabled.

---
 rtl/sequenciador_medicao_if.sv | 25 ++
 rtl/sequenciador_medicao.sv | 143 ++++++++++++++
 tb/tb_sequenciador_medicao.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_medicao_if.sv
// Sensor and classifier handshake bundle for the level-measurement sequencer.
interface sequenciador_medicao_if;
  logic        pede_medida;
  logic        medida_pronta;
  logic [11:0] medida_in;
  logic        zera_class;
  logic        iniciar_class;
  logic [11:0] medida1;
  logic [11:0] medida2;
  logic [11:0] medida3;
  logic        fim_classificacao;
  logic        descartar_medida;
  logic [11:0] media_in;
  logic [2:0]  classe_in;

  modport master (
    output pede_medida, zera_class, iniciar_class, medida1, medida2, medida3,
    input  medida_pronta, medida_in, fim_classificacao, descartar_medida, media_in, classe_in
  );

  modport slave (
    input  pede_medida, zera_class, iniciar_class, medida1, medida2, medida3,
    output medida_pronta, medida_in, fim_classificacao, descartar_medida, media_in, classe_in
  );
endinterface

// File: rtl/sequenciador_medicao.sv
// Sequences one water-level measurement: three sensor samples, classifier clear/start,
// publish average/class, retry on discard, repeat every INTERVALO cycles while enabled.
module sequenciador_medicao #(
  parameter int INTERVALO      = 1000,
  parameter int TIMEOUT        = 50000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic                          clock,
  input  logic                          zera,
  input  logic                          ligar,
  sequenciador_medicao_if.master        bus,
  output logic [11:0]                   media_out,
  output logic [2:0]                    classe_out,
  output logic                          atualiza,
  output logic                          falha_medida,
  output logic                          erro_sensor,
  output logic                          ocupado
);

  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam int IW  = $clog2(INTERVALO) + 1;
  localparam int NW  = $clog2(MAX_TENTATIVAS) + 1;

  typedef enum logic [2:0] {
    OCIOSO, PEDE, AGUARDA, LIMPA, INICIA, ESPERA_CLASS, INTERVALO_ST, ERRO
  } estado_t;

  estado_t         estado, prox;
  logic [TW-1:0]   tcnt;
  logic [IW-1:0]   icnt;
  logic [NW-1:0]   tent;
  logic [1:0]      idx;
  logic [11:0]     m1, m2, m3;
  logic            erro_r;

  logic amostra, estourou, fim_ok, fim_desc, esgotou, expira;

  assign amostra  = (estado == AGUARDA) && bus.medida_pronta;
  assign estourou = (estado == AGUARDA) && !bus.medida_pronta && (tcnt == TW'(TIMEOUT - 1));
  assign fim_ok   = (estado == ESPERA_CLASS) && bus.fim_classificacao && !bus.descartar_medida;
  assign fim_desc = (estado == ESPERA_CLASS) && bus.fim_classificacao && bus.descartar_medida;
  assign esgotou  = (tent == NW'(MAX_TENTATIVAS - 1));
  assign expira   = (estado == INTERVALO_ST) && (icnt == IW'(INTERVALO - 2));

  always_ff @(posedge clock) begin
    if (zera) estado <= OCIOSO;
    else      estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:       if (ligar) prox = PEDE;
      PEDE:         prox = AGUARDA;
      AGUARDA: begin
        if (amostra)       prox = (idx == 2'd2) ? LIMPA : PEDE;
        else if (estourou) prox = ERRO;
      end
      LIMPA:        prox = INICIA;
      INICIA:       prox = ESPERA_CLASS;
      ESPERA_CLASS: begin
        if (fim_ok)                  prox = INTERVALO_ST;
        else if (fim_desc && esgotou) prox = INTERVALO_ST;
        else if (fim_desc)           prox = PEDE;
      end
      INTERVALO_ST: if (expira) prox = ligar ? PEDE : OCIOSO;
      ERRO:         if (!ligar) prox = OCIOSO;
      default:      prox = OCIOSO;
    endcase
  end

  always_comb begin
    bus.pede_medida   = (estado == PEDE);
    bus.zera_class    = (estado == LIMPA);
    bus.iniciar_class = (estado == INICIA);
    atualiza          = fim_ok;
    falha_medida      = fim_desc && esgotou;
    ocupado           = (estado != OCIOSO) && (estado != ERRO);
  end

  // Counters are loaded so the timeout and interval land on exact cycle counts
  // from the pede_medida / atualiza pulses.
  always_ff @(posedge clock) begin
    if (zera) begin
      tcnt       <= '0;
      icnt       <= '0;
      tent       <= '0;
      idx        <= '0;
      m1         <= '0;
      m2         <= '0;
      m3         <= '0;
      erro_r     <= 1'b0;
      media_out  <= '0;
      classe_out <= '0;
    end else begin
      icnt <= (estado == INTERVALO_ST) ? icnt + 1'b1 : '0;
      case (estado)
        OCIOSO: if (ligar) begin
          tent   <= '0;
          idx    <= '0;
          erro_r <= 1'b0;
        end
        PEDE: tcnt <= TW'(1);
        AGUARDA: begin
          if (amostra) begin
            case (idx)
              2'd0:    m1 <= bus.medida_in;
              2'd1:    m2 <= bus.medida_in;
              2'd2:    m3 <= bus.medida_in;
              default: ;
            endcase
            idx <= idx + 2'd1;
          end else if (estourou) begin
            erro_r <= 1'b1;
          end else if (tcnt < TW'(TIMEOUT)) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ESPERA_CLASS: begin
          if (fim_ok) begin
            media_out  <= bus.media_in;
            classe_out <= bus.classe_in;
          end
          if (fim_desc) begin
            tent <= tent + 1'b1;
            idx  <= '0;
          end
        end
        INTERVALO_ST: if (expira) begin
          tent <= '0;
          idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.medida1 = m1;
  assign bus.medida2 = m2;
  assign bus.medida3 = m3;
  assign erro_sensor = erro_r;

endmodule

// File: tb/tb_sequenciador_medicao.sv
// Directed bench with sensor/classifier models and an atualiza scoreboard.
module tb_sequenciador_medicao;
  logic        clock = 1'b0;
  logic        zera;
  logic        ligar;
  logic [11:0] media_out;
  logic [2:0]  classe_out;
  logic        atualiza, falha_medida, erro_sensor, ocupado;

  sequenciador_medicao_if bus();

  sequenciador_medicao #(.INTERVALO(10), .TIMEOUT(20), .MAX_TENTATIVAS(3)) dut (
    .clock(clock), .zera(zera), .ligar(ligar), .bus(bus),
    .media_out(media_out), .classe_out(classe_out), .atualiza(atualiza),
    .falha_medida(falha_medida), .erro_sensor(erro_sensor), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_pede = 0, n_zera = 0, n_ini = 0, n_atu = 0, n_falha = 0;
  int t_zera = 0, t_ini = 0;
  int sdly = 0, s_k = 0, s_left = -1, cdly = 0;
  logic [11:0] cls_media = 12'h0;
  logic [2:0]  cls_classe = 3'h0;
  bit          plan[$];
  logic [14:0] sb[$];

  localparam int SEL_PEDE = 0, SEL_ATU = 1, SEL_FALHA = 2, SEL_ERRO = 3, SEL_INI = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input int sel, input int budget, input string tag, output int t);
    int  n;
    bit  hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      @(negedge clock);
      n++;
      case (sel)
        SEL_PEDE:  hit = bus.pede_medida;
        SEL_ATU:   hit = atualiza;
        SEL_FALHA: hit = falha_medida;
        SEL_ERRO:  hit = erro_sensor;
        default:   hit = bus.iniciar_class;
      endcase
    end
    t = cyc;
    chk({tag, "_seen"}, {31'd0, hit}, 32'd1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Sensor: answers 5 cycles after each request with 0x200, 0x201, 0x202, ...
  initial begin
    bus.medida_pronta = 1'b0;
    bus.medida_in     = '0;
    forever begin
      @(posedge clock); #1;
      bus.medida_pronta = 1'b0;
      if (sdly > 0) begin
        sdly--;
        if (sdly == 0) begin
          bus.medida_pronta = 1'b1;
          bus.medida_in     = 12'h200 + 12'(s_k);
          s_k = (s_k == 2) ? 0 : s_k + 1;
        end
      end
      if (bus.pede_medida && s_left != 0) begin
        sdly = 5;
        if (s_left > 0) s_left--;
      end
    end
  end

  // Classifier: fim sticky until zera_class, 3 cycles after iniciar_class.
  initial begin
    bus.fim_classificacao = 1'b0;
    bus.descartar_medida  = 1'b0;
    bus.media_in          = '0;
    bus.classe_in         = '0;
    forever begin
      @(posedge clock); #1;
      if (bus.zera_class) bus.fim_classificacao = 1'b0;
      if (cdly > 0) begin
        cdly--;
        if (cdly == 0) begin
          bus.fim_classificacao = 1'b1;
          bus.descartar_medida  = (plan.size() > 0) ? plan.pop_front() : 1'b0;
          bus.media_in          = cls_media;
          bus.classe_in         = cls_classe;
        end
      end
      if (bus.iniciar_class) cdly = 3;
    end
  end

  // Monitor: pulse counters and scoreboard check one cycle after atualiza.
  initial begin
    bit          pend;
    logic [14:0] e;
    pend = 0;
    forever begin
      @(negedge clock);
      if (pend) begin
        chk("sb_pending", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_media_classe", {17'd0, media_out, classe_out}, {17'd0, e});
        end
      end
      pend = atualiza;
      if (bus.pede_medida)   n_pede++;
      if (bus.zera_class)    begin n_zera++; t_zera = cyc; end
      if (bus.iniciar_class) begin n_ini++;  t_ini  = cyc; end
      if (atualiza)          n_atu++;
      if (falha_medida)      n_falha++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a, t_p, t_e, np, nz, ni, na, nf;
    zera = 1'b1;
    ligar = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pede", {31'd0, bus.pede_medida}, 32'd0);
    chk("rst_medida1", {20'd0, bus.medida1}, 32'd0);
    chk("rst_media", {20'd0, media_out}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_erro", {31'd0, erro_sensor}, 32'd0);
    zera = 1'b0;

    // Nominal cycle
    cls_media = 12'h201; cls_classe = 3'b010;
    sb.push_back({12'h201, 3'b010});
    ligar = 1'b1;
    wait_for(SEL_ATU, 200, "nom_atualiza", t_a);
    chk("nom_medida1", {20'd0, bus.medida1}, 32'h200);
    chk("nom_medida2", {20'd0, bus.medida2}, 32'h201);
    chk("nom_medida3", {20'd0, bus.medida3}, 32'h202);
    chk("nom_zera_ini_gap", t_ini - t_zera, 32'd1);
    wait_for(SEL_PEDE, 50, "int_pede", t_p);
    chk("int_gap", t_p - t_a, 32'd10);

    // Stop mid-cycle: ligar drops in AGUARDA, cycle still completes
    ligar = 1'b0;
    cls_media = 12'h155; cls_classe = 3'd5;
    sb.push_back({12'h155, 3'd5});
    wait_for(SEL_ATU, 100, "stop_atualiza", t_a);
    np = n_pede;
    idle(30);
    chk("stop_no_pede", n_pede - np, 32'd0);
    chk("stop_ocupado", {31'd0, ocupado}, 32'd0);

    // Discard once, then accept
    s_k = 0;
    plan.push_back(1'b1); plan.push_back(1'b0);
    cls_media = 12'h0AB; cls_classe = 3'd1;
    sb.push_back({12'h0AB, 3'd1});
    np = n_pede; nz = n_zera; ni = n_ini; na = n_atu; nf = n_falha;
    ligar = 1'b1;
    wait_for(SEL_ATU, 400, "retry_atualiza", t_a);
    ligar = 1'b0;
    idle(30);
    chk("retry_pede", n_pede - np, 32'd6);
    chk("retry_zera", n_zera - nz, 32'd2);
    chk("retry_ini", n_ini - ni, 32'd2);
    chk("retry_atu", n_atu - na, 32'd1);
    chk("retry_falha", n_falha - nf, 32'd0);

    // Discard exhaustion
    s_k = 0;
    plan.push_back(1'b1); plan.push_back(1'b1); plan.push_back(1'b1);
    cls_media = 12'h777; cls_classe = 3'd6;
    np = n_pede; na = n_atu; nf = n_falha;
    ligar = 1'b1;
    wait_for(SEL_FALHA, 400, "exh_falha", t_a);
    ligar = 1'b0;
    idle(30);
    chk("exh_pede", n_pede - np, 32'd9);
    chk("exh_falha_cnt", n_falha - nf, 32'd1);
    chk("exh_atu", n_atu - na, 32'd0);
    chk("exh_media_kept", {20'd0, media_out}, 32'h0AB);
    chk("exh_classe_kept", {29'd0, classe_out}, 32'd1);

    // Sensor timeout after the second request
    s_k = 0; s_left = 1;
    ligar = 1'b1;
    wait_for(SEL_PEDE, 10, "to_pede1", t_p);
    wait_for(SEL_PEDE, 20, "to_pede2", t_p);
    wait_for(SEL_ERRO, 40, "to_erro", t_e);
    chk("to_gap", t_e - t_p, 32'd20);
    idle(3);
    chk("to_erro_hold", {31'd0, erro_sensor}, 32'd1);
    chk("to_ocupado_erro", {31'd0, ocupado}, 32'd0);
    ligar = 1'b0;
    idle(2);
    chk("to_ocupado_idle", {31'd0, ocupado}, 32'd0);

    // Reset during ESPERA_CLASS
    s_k = 0; s_left = -1;
    cls_media = 12'h3C3; cls_classe = 3'd3;
    ligar = 1'b1;
    wait_for(SEL_PEDE, 10, "rmo_pede", t_p);
    chk("rmo_erro_cleared", {31'd0, erro_sensor}, 32'd0);
    wait_for(SEL_INI, 200, "rmo_ini", t_p);
    @(negedge clock);
    zera = 1'b1; ligar = 1'b0;
    @(negedge clock); #1;
    chk("rmo_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rmo_media", {20'd0, media_out}, 32'd0);
    chk("rmo_classe", {29'd0, classe_out}, 32'd0);
    chk("rmo_medida1", {20'd0, bus.medida1}, 32'd0);
    chk("rmo_medida3", {20'd0, bus.medida3}, 32'd0);
    chk("rmo_strobes", {28'd0, bus.pede_medida, bus.zera_class, bus.iniciar_class, falha_medida}, 32'd0);
    zera = 1'b0;
    na = n_atu;
    idle(20);
    chk("rmo_fim_ignored", n_atu - na, 32'd0);
    chk("rmo_idle", {31'd0, ocupado}, 32'd0);
    chk("rmo_media_after", {20'd0, media_out}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
